// File: rtl/cr_demux_2_reg.sv
// cr_demux_2_reg: 1-to-2 registered demultiplexer with valid/ready on every port.
// Each output port owns one holding register and a full flag. The beat goes to the
// port chosen by in_sel. Optional per-port delivered-beat counters are compiled in
// when the macro CR_DEMUX_2_REG_CNT_EN is defined. Otherwise cnt0/cnt1 are tied to 0.

// One output port: holding register, full flag, optional delivered-beat counter.
module cr_demux_2_reg_port #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    input  logic             cnt_clr,
    output logic             full,
    output logic [WIDTH-1:0] data,
    output logic [15:0]      cnt
);
    logic take;

    assign take = full & ready;

    // A load wins over a drain, so a port can deliver one beat back-to-back every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            data <= din;
        end else if (take) begin
            full <= 1'b0;
        end
    end

`ifdef CR_DEMUX_2_REG_CNT_EN
    // Delivered-beat count. It wraps at 16 bits. A clear takes priority over an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt <= '0;
        else if (cnt_clr) cnt <= '0;
        else if (take)    cnt <= cnt + 16'd1;
    end
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign cnt            = '0;
`endif
endmodule

// Top: steers each accepted beat to the selected port. The ports drain independently.
module cr_demux_2_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out0_valid,
    output logic [WIDTH-1:0] out0_data,
    input  logic             out0_ready,
    output logic             out1_valid,
    output logic [WIDTH-1:0] out1_data,
    input  logic             out1_ready,
    input  logic             cnt_clr,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
);
    logic [1:0]            full;
    logic [1:0]            out_ready;
    logic [1:0]            load;
    logic [1:0][WIDTH-1:0] data;
    logic [1:0][15:0]      cnt;

    assign out_ready = {out1_ready, out0_ready};

    // The selected port can accept a beat if it is empty or is draining this cycle.
    // This path is independent of in_valid.
    assign in_ready = ~full[in_sel] | out_ready[in_sel];

    for (genvar k = 0; k < 2; k++) begin : g_port
        assign load[k] = in_valid & in_ready & (in_sel == 1'(k));

        cr_demux_2_reg_port #(.WIDTH(WIDTH)) u_port (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (load[k]),
            .din     (in_data),
            .ready   (out_ready[k]),
            .cnt_clr (cnt_clr),
            .full    (full[k]),
            .data    (data[k]),
            .cnt     (cnt[k])
        );
    end

    assign out0_valid = full[0];
    assign out1_valid = full[1];
    assign out0_data  = data[0];
    assign out1_data  = data[1];
    assign cnt0       = cnt[0];
    assign cnt1       = cnt[1];
endmodule
